// File: rtl/decrypt_sequencer_if.sv
// decrypt_sequencer_if: launch handshake plus data-memory port; slave = sequencer, master = launcher/memory side
interface decrypt_sequencer_if #(
    parameter int AW = 8
);
    logic          req;
    logic          ack;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  req,
        input  mem_rdata,
        output ack,
        output err,
        output mem_addr,
        output mem_we,
        output mem_wdata
    );

    modport master (
        output req,
        output mem_rdata,
        input  ack,
        input  err,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata
    );
endinterface

// File: rtl/decrypt_sequencer.sv
// decrypt_sequencer: recovers LFSR taps/seed from the space preamble, decrypts the message and writes plaintext; optional macro DECRYPT_PARITY_CHECK_EN
module decrypt_sequencer #(
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 0,
    parameter int MSG_LEN   = 64,
    parameter int TRAIN_LEN = 10,
    parameter int AW        = 8
) (
    input logic               clk,
    input logic               init,
    decrypt_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DEC_RD, DEC_WR, DONE} state_t;

    localparam int CW = $clog2(MSG_LEN + TRAIN_LEN + 2);
    localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [6:0]    lfsr_q, lfsr_d;
    logic [6:0]    pat_q, pat_d;
    logic          seen_q, seen_d;
    logic          err_q, err_d;
    logic [6:0]    trn_q [TRAIN_LEN];
    logic [6:0]    trn_d [TRAIN_LEN];
    logic          match;
    logic [6:0]    plain;
    logic          flag;

    assign plain = bus.mem_rdata[6:0] ^ lfsr_q;
`ifdef DECRYPT_PARITY_CHECK_EN
    assign flag = ^bus.mem_rdata;
`else
    logic unused_msb;
    assign flag = 1'b0;
    assign unused_msb = bus.mem_rdata[7];
`endif

    assign bus.ack = (state_q == DONE);
    assign bus.err = err_q;

    // candidate TAPS[idx] must reproduce every preamble transition from a nonzero start state
    always_comb begin
        match = (trn_q[0] != 7'h0);
        for (int k = 0; k < TRAIN_LEN - 1; k++)
            if (lfsr_step(trn_q[k], TAPS[idx_q]) != trn_q[k+1]) match = 1'b0;
    end

    // next-state, counters and memory port drive
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wcnt_d        = wcnt_q;
        idx_d         = idx_q;
        lfsr_d        = lfsr_q;
        pat_d         = pat_q;
        seen_d        = seen_q;
        err_d         = err_q;
        trn_d         = trn_q;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 8'h00;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                wcnt_d  = '0;
                idx_d   = '0;
                seen_d  = 1'b0;
                err_d   = 1'b0;
                state_d = bus.req ? IDLE : LOAD;
            end
            LOAD: begin
                bus.mem_addr = AW'(SRC_BASE) + AW'(cnt_q);
                for (int k = 0; k < TRAIN_LEN; k++)
                    if (cnt_q == CW'(k + 1)) trn_d[k] = bus.mem_rdata[6:0];
                cnt_d   = (cnt_q == CW'(TRAIN_LEN)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(TRAIN_LEN)) ? SEARCH : LOAD;
            end
            SEARCH: begin
                if (match) begin
                    pat_d   = TAPS[idx_q];
                    lfsr_d  = trn_q[0];
                    state_d = DEC_RD;
                end else if (idx_q == 4'd8) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DEC_RD: begin
                bus.mem_addr = AW'(SRC_BASE) + AW'(cnt_q);
                state_d      = DEC_WR;
            end
            DEC_WR: begin
                bus.mem_addr  = AW'(DST_BASE) + AW'(wcnt_q);
                bus.mem_we    = seen_q || (plain != 7'h0) || flag;
                bus.mem_wdata = {flag, plain};
                wcnt_d        = bus.mem_we ? wcnt_q + 1'b1 : wcnt_q;
                seen_d        = seen_q || bus.mem_we;
                lfsr_d        = lfsr_step(lfsr_q, pat_q);
                cnt_d         = cnt_q + 1'b1;
                state_d       = (cnt_q == CW'(MSG_LEN - 1)) ? DONE : DEC_RD;
            end
            DONE: begin
                state_d = bus.req ? IDLE : DONE;
                err_d   = bus.req ? 1'b0 : err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; init aborts any run on the next edge
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            lfsr_q  <= '0;
            pat_q   <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            trn_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            pat_q   <= pat_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            trn_q   <= trn_d;
        end
    end
endmodule

// File: tb/tb_decrypt_sequencer.sv
// tb_decrypt_sequencer: directed and random runs of decrypt_sequencer against a plaintext-level reference model
module tb_decrypt_sequencer;
`ifdef DECRYPT_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    logic clk = 1'b0;
    logic init = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] src_mem [256];
    logic [7:0] wa_q [$];
    logic [7:0] wd_q [$];
    logic [7:0] exp_q [$];
    int exp_m;

    decrypt_sequencer_if #(.AW(8)) bus ();

    decrypt_sequencer dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // memory with one-cycle read latency; writes are only logged
    always @(posedge clk) begin
        bus.mem_rdata <= src_mem[bus.mem_addr];
        if (bus.mem_we === 1'b1) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
        end
    end

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // encrypt 10-space preamble + msg padded with spaces to 64 bytes
    task automatic build(input int ti, input logic [6:0] s0, input string msg, input int flip);
        logic [6:0] s, pl, e;
        s = s0;
        for (int k = 0; k < 64; k++) begin
            pl = (k >= 10 && k - 10 < msg.len()) ? 7'(msg[k-10] - 8'h20) : 7'h0;
            e = pl ^ s;
            src_mem[64+k] = {PAR ? ^e : 1'($urandom), e};
            s = step(s, TAPS[ti]);
        end
        if (flip >= 0) src_mem[64+flip] = src_mem[64+flip] ^ 8'h04;
    endtask

    // search taps from the ciphertext alone, then produce the expected write stream
    task automatic model();
        logic [6:0] s, pl;
        logic [7:0] e;
        bit ok, seen, f;
        exp_q.delete();
        exp_m = -1;
        for (int i = 0; i < 9; i++) begin
            ok = (exp_m < 0) && (src_mem[64][6:0] != 7'h0);
            for (int k = 0; k < 9; k++)
                if (step(src_mem[64+k][6:0], TAPS[i]) != src_mem[65+k][6:0]) ok = 1'b0;
            if (ok) exp_m = i;
        end
        if (exp_m >= 0) begin
            s = src_mem[64][6:0];
            seen = 1'b0;
            for (int k = 0; k < 64; k++) begin
                e = src_mem[64+k];
                pl = e[6:0] ^ s;
                f = PAR & (^e);
                if (seen || pl != 7'h0 || f) begin
                    seen = 1'b1;
                    exp_q.push_back({f, pl});
                end
                s = step(s, TAPS[exp_m]);
            end
        end
    endtask

    task automatic run_check(input string tag, input int exp_n);
        int n;
        bit done;
        bus.req = 1'b1;
        repeat (3) @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        bus.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        check({tag, " first_addr"}, 32'(bus.mem_addr), 32'd64);
        done = bus.ack;
        while (!done && n < 600) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            done = bus.ack;
        end
        check({tag, " ack"}, 32'(bus.ack), 32'd1);
        check({tag, " cycles"}, 32'(n), 32'(exp_n));
        check({tag, " err"}, 32'(bus.err), 32'(exp_m < 0));
        check({tag, " nwrites"}, 32'(wa_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < wa_q.size() && j < exp_q.size(); j++) begin
            check($sformatf("%s waddr%0d", tag, j), 32'(wa_q[j]), 32'(j));
            check($sformatf("%s wdata%0d", tag, j), 32'(wd_q[j]), 32'(exp_q[j]));
        end
        bus.req = 1'b1;
    endtask

    initial begin
        int n;
        bit hit;
        string msg;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        bus.req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst ack", 32'(bus.ack), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        check("rst we", 32'(bus.mem_we), 32'd0);
        check("rst addr", 32'(bus.mem_addr), 32'd0);
        check("rst wdata", 32'(bus.mem_wdata), 32'd0);
        init = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold we", 32'(bus.mem_we), 32'd0);
            check("hold addr", 32'(bus.mem_addr), 32'd0);
        end
        build(0, 7'h01, "          Ajok          ", -1);
        model();
        run_check("ajok", 141 + exp_m);
        check("ajok nwr", 32'(wa_q.size()), 32'd44);
        check("ajok m0", 32'(wd_q[0]), 32'h21);
        check("ajok m1", 32'(wd_q[1]), 32'h4A);
        check("ajok m2", 32'(wd_q[2]), 32'h4F);
        check("ajok m3", 32'(wd_q[3]), 32'h4B);
        for (int t = 0; t < 9; t++) begin
            build(t, 7'h55, "Mr. Watson", -1);
            model();
            run_check($sformatf("tap%0d", t), 141 + t);
            check($sformatf("tap%0d m0", t), 32'(wd_q[0]), 32'h2D);
        end
        for (int i = 64; i < 128; i++) src_mem[i] = 8'h00;
        model();
        run_check("zero", 21);
        check("zero err", 32'(bus.err), 32'd1);
        check("zero nwr", 32'(wa_q.size()), 32'd0);
        build(4, 7'h2B, "Hello parity world of the sequencer", 30);
        model();
        run_check("parity", 141 + exp_m);
        check("parity b7", 32'(wd_q[0][7]), 32'd0);
        build(3, 7'h55, "Mr. Watson come here", -1);
        model();
        bus.req = 1'b1;
        repeat (3) @(negedge clk);
        bus.req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            hit = bus.mem_we;
        end
        check("abort reached_wr", 32'(hit), 32'd1);
        init = 1'b1;
        bus.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort ack", 32'(bus.ack), 32'd0);
        check("abort we", 32'(bus.mem_we), 32'd0);
        check("abort addr", 32'(bus.mem_addr), 32'd0);
        init = 1'b0;
        wa_q.delete();
        wd_q.delete();
        repeat (20) @(negedge clk);
        check("abort nowrite", 32'(wa_q.size()), 32'd0);
        run_check("rerun", 141 + exp_m);
        for (int r = 0; r < 5; r++) begin
            msg = "";
            n = $urandom_range(0, 54);
            for (int i = 0; i < n; i++)
                msg = {msg, string'(8'($urandom_range(0, 3) == 0 ? 32'h20 : $urandom_range(32'h21, 32'h7E)))};
            build($urandom_range(0, 8), 7'($urandom_range(1, 127)), msg,
                  PAR ? int'($urandom_range(10, 63)) : -1);
            model();
            run_check($sformatf("rnd%0d", r), exp_m < 0 ? 21 : 141 + exp_m);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decrypt_sequencer.md
Name: decrypt_sequencer

Overview:
- Hardware sequencer for the message-decryption task (Program 3 flow).
- Reads an LFSR-encrypted message from data memory and recovers the LFSR tap pattern and start state from the known all-space preamble.
- Decrypts every byte, strips leading spaces, and writes the plaintext (offset -0x20) back to memory.
- Sits beside the data memory inside top_level, owns the memory port while running, and answers the req/ack launch handshake.

Parameters:
- SRC_BASE, 64: address of encrypted byte 0.
- DST_BASE, 0: address of first plaintext output byte.
- MSG_LEN, 64: encrypted bytes processed.
- TRAIN_LEN, 10: preamble bytes used for pattern search (minimum preamble length, ≥ 2).
- AW, 8: memory address width.

Ports:
- clk  in  1  system clock.
- init  in  1  reset; synchronous, active-high.
- req  in  1  launch request; held high = hold in IDLE; run starts on first clock in IDLE with req=0.
- ack  out  1  run complete; high in DONE.
- err  out  1  no candidate pattern matched; valid while ack=1.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  read data; valid the cycle after mem_addr is presented (1-cycle latency).

Behaviour:
- Reset (init=1 at posedge): state=IDLE; ack=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0; all counters and buffers cleared. init mid-run aborts immediately; no further writes occur.
- Candidate taps, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: next(s,p) = {s[5:0], ^(s & p)}, 7 bits.
- IDLE: wait for req=0, then go to LOAD.
- LOAD:
  - Issue addresses SRC_BASE..SRC_BASE+TRAIN_LEN-1 on consecutive cycles.
  - Capture mem_rdata[6:0] one cycle later into buf[0..TRAIN_LEN-1]; takes TRAIN_LEN+1 cycles.
  - Then go to SEARCH.
- SEARCH:
  - One candidate per cycle, index 0 upward.
  - Candidate p matches iff next(buf[k],p)==buf[k+1] for all k in 0..TRAIN_LEN-2. This is evaluated combinationally.
  - First match: latch p, set lfsr=buf[0], go to DEC_RD.
  - buf[0]==0 counts as no match (zero state is illegal).
  - After index 8 with no match: err=1, go to DONE.
- DEC_RD / DEC_WR (2 cycles per byte, i = 0..MSG_LEN-1):
  - DEC_RD issues SRC_BASE+i.
  - DEC_WR computes plain = mem_rdata[6:0] ^ lfsr.
  - While no nonzero plain has been seen, plain==0 is skipped (leading space, no write).
  - Otherwise the write is mem_addr = DST_BASE+wcnt, mem_we=1, mem_wdata = {flag, plain}; then wcnt++.
  - lfsr advances every byte, whether written or skipped.
  - After i=MSG_LEN-1, go to DONE.
- Embedded spaces after the first non-space are written as 0x00.
- An all-space message writes nothing.
- DONE: ack=1, mem_we=0. Hold until req=1, then go to IDLE and clear ack and err.
- Writes total MSG_LEN minus the number of leading plaintext spaces (preamble included). Output addresses never exceed DST_BASE+MSG_LEN-1.
- mem_we is asserted only in DEC_WR.

Optional Feature:
- DECRYPT_PARITY_CHECK_EN defined:
  - flag = ^mem_rdata[7:0] (encrypted bit 7 is expected to be even parity over [6:0]).
  - A mismatch sets output bit 7; the 7-bit plaintext is still written.
  - A flagged byte counts as non-space and always ends leading-space skipping.
  - Parity is ignored during SEARCH.
- Not defined: flag = 0; encrypted bit 7 is ignored everywhere.

Test Plan:
- Taps 0x60, init 0x01, preamble 10, msg "          Ajok          ":
  - 20 leading spaces are skipped; mem[0]=0x21, mem[1]=0x4A, mem[2]=0x4F, mem[3]=0x4B.
  - 44 writes total; ack=1, err=0.
- Each tap index 0..8 with init 0x55, msg "Mr. Watson": mem[0]=0x2D ('M'-0x20), and the latched pattern index equals the tap index used.
- All encrypted bytes 0x00: err=1 and ack=1 after LOAD plus 9 SEARCH cycles; zero writes.
- With DECRYPT_PARITY_CHECK_EN, flip bit 2 of encrypted byte 30:
  - The corresponding output byte has bit 7 = 1; all other bytes have bit 7 = 0.
  - Without the macro, the same stimulus gives a differing bit 2 and bit 7 = 0.
- Assert init for one cycle during DEC_WR:
  - Next cycle: IDLE, ack=0, mem_we=0; no write after reset.
  - Rerun with req produces correct output.
- Hold req=1 after reset for 20 cycles: stays in IDLE with mem_we=0. Drop req: first read at SRC_BASE on the next cycle.
